karatsuba_mod_reducer: RTL and testbench

- Consumes the three registered Karatsuba partial products (H, M, L) from the 130x130 multiplier stage.
- Recombines them into the full product of two 256-bit operands.
- Reduces that product modulo p = 2^255 - 19 to a canonical 255-bit residue.
- Sits between the multiplier and the field-arithmetic controller, with valid/ready handshakes on both sides.

---
 rtl/karatsuba_mod_reducer.sv | 131 +++++++++++++
 tb/tb_karatsuba_mod_reducer.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/karatsuba_mod_reducer.sv
// Recombines Karatsuba partial products (H, M, L) into a 512-bit product and
// reduces it modulo p = 2^255 - 19 through two folds and one conditional subtract.
module karatsuba_mod_reducer #(
  parameter int D_WIDTH = 260,
  parameter int HALF    = 128,
  parameter int R_WIDTH = 255
) (
  input  logic               i_clk,
  input  logic               i_rst,
  input  logic               i_valid,
  output logic               o_ready,
  input  logic [D_WIDTH-1:0] i_H,
  input  logic [D_WIDTH-1:0] i_M,
  input  logic [D_WIDTH-1:0] i_L,
  output logic               o_valid,
  input  logic               i_ready,
  output logic [R_WIDTH-1:0] o_result
);

  localparam int P_W   = 4 * HALF;       // full product width
  localparam int MID_W = D_WIDTH + 1;    // middle term width
  localparam int HI_W  = P_W - R_WIDTH;  // bits above 2^255 in P
  localparam int R1_W  = R_WIDTH + 8;    // first fold result width
  localparam int R2_W  = R_WIDTH + 1;    // second fold result width

  localparam logic [R1_W-1:0] K19_R1   = 19;
  localparam logic [R2_W-1:0] K19_R2   = 19;
  localparam logic [R2_W-1:0] K18      = 18;
  localparam logic [R2_W-1:0] P_MOD    = {1'b0, {R_WIDTH{1'b1}}} - K18;
  localparam logic [R_WIDTH-1:0] P_LOW = P_MOD[R_WIDTH-1:0];

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_CMB  = 3'd1,
    S_FD1  = 3'd2,
    S_FD2  = 3'd3,
    S_SUB  = 3'd4,
    S_OUT  = 3'd5
  } state_t;

  state_t             state_q;
  logic               ready_q;
  logic               valid_q;
  logic [D_WIDTH-1:0] h_q, m_q, l_q;
  logic [P_W-1:0]     p_q;
  logic [R1_W-1:0]    r1_q;
  logic [R2_W-1:0]    r2_q;
  logic [R_WIDTH-1:0] result_q;

  logic [MID_W-1:0]   mid_d;
  logic [P_W-1:0]     p_d;
  logic [R1_W-1:0]    r1_d;
  logic [R2_W-1:0]    r2_d;
  logic [R_WIDTH-1:0] res_d;

  // Middle term wraps mod 2^261 if the producer breaks M >= H + L.
  assign mid_d = {1'b0, m_q} - {1'b0, h_q} - {1'b0, l_q};
  assign p_d   = ({{(P_W - D_WIDTH){1'b0}}, h_q} << (2 * HALF))
               + ({{(P_W - MID_W){1'b0}}, mid_d} << HALF)
               + {{(P_W - D_WIDTH){1'b0}}, l_q};

  // 2^255 == 19 (mod p): fold the high part back in twice.
  assign r1_d = {{(R1_W - R_WIDTH){1'b0}}, p_q[R_WIDTH-1:0]}
              + ({{(R1_W - HI_W){1'b0}}, p_q[P_W-1:R_WIDTH]} * K19_R1);
  assign r2_d = {{(R2_W - R_WIDTH){1'b0}}, r1_q[R_WIDTH-1:0]}
              + ({{(R2_W - 8){1'b0}}, r1_q[R1_W-1:R_WIDTH]} * K19_R2);

  // r2 - p < 2^255 whenever r2 >= p, so the low 255 bits of the difference suffice.
  assign res_d = (r2_q >= P_MOD) ? (r2_q[R_WIDTH-1:0] - P_LOW) : r2_q[R_WIDTH-1:0];

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q  <= S_IDLE;
      ready_q  <= 1'b1;
      valid_q  <= 1'b0;
      h_q      <= '0;
      m_q      <= '0;
      l_q      <= '0;
      p_q      <= '0;
      r1_q     <= '0;
      r2_q     <= '0;
      result_q <= '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (i_valid) begin
            h_q     <= i_H;
            m_q     <= i_M;
            l_q     <= i_L;
            ready_q <= 1'b0;
            state_q <= S_CMB;
          end
        end
        S_CMB: begin
          p_q     <= p_d;
          state_q <= S_FD1;
        end
        S_FD1: begin
          r1_q    <= r1_d;
          state_q <= S_FD2;
        end
        S_FD2: begin
          r2_q    <= r2_d;
          state_q <= S_SUB;
        end
        S_SUB: begin
          result_q <= res_d;
          valid_q  <= 1'b1;
          state_q  <= S_OUT;
        end
        S_OUT: begin
          if (i_ready) begin
            valid_q <= 1'b0;
            ready_q <= 1'b1;
            state_q <= S_IDLE;
          end
        end
        default: begin
          valid_q <= 1'b0;
          ready_q <= 1'b1;
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  assign o_ready  = ready_q;
  assign o_valid  = valid_q;
  assign o_result = result_q;

endmodule

// File: tb/tb_karatsuba_mod_reducer.sv
// Scoreboard bench for karatsuba_mod_reducer: stimulus pushes expected residues,
// a negedge monitor pops and compares on every o_valid && i_ready transfer.
module tb_karatsuba_mod_reducer;

  localparam int D_WIDTH = 260;
  localparam int R_WIDTH = 255;
  localparam logic [255:0] P_MOD = {1'b0, {255{1'b1}}} - 256'd18;

  logic               i_clk;
  logic               i_rst;
  logic               i_valid;
  logic               o_ready;
  logic [D_WIDTH-1:0] i_H, i_M, i_L;
  logic               o_valid;
  logic               i_ready;
  logic [R_WIDTH-1:0] o_result;

  karatsuba_mod_reducer dut (
    .i_clk   (i_clk),
    .i_rst   (i_rst),
    .i_valid (i_valid),
    .o_ready (o_ready),
    .i_H     (i_H),
    .i_M     (i_M),
    .i_L     (i_L),
    .o_valid (o_valid),
    .i_ready (i_ready),
    .o_result(o_result)
  );

  int checks = 0;
  int failures = 0;
  int n_in = 0;
  int n_out = 0;
  logic [R_WIDTH-1:0] exp_q[$];
  logic [R_WIDTH-1:0] mon_exp;
  bit stall_en;

  initial begin
    i_clk = 1'b0;
    forever #5 i_clk = ~i_clk;
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog expired got=running exp=finished");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [259:0] got, input logic [259:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", name, got, exp);
    end
  endtask

  function automatic logic [R_WIDTH-1:0] golden(input logic [255:0] a, input logic [255:0] b);
    logic [511:0] prod;
    logic [511:0] rem;
    prod = {256'd0, a} * {256'd0, b};
    rem  = prod % {256'd0, P_MOD};
    return rem[R_WIDTH-1:0];
  endfunction

  // Monitor: one transfer per cycle where o_valid and i_ready are both high.
  always @(negedge i_clk) begin
    if (!i_rst && o_valid && i_ready) begin
      checks++;
      n_out++;
      if (exp_q.size() == 0) begin
        failures++;
        $display("FAIL result_unexpected idx=%0d got=%0h exp=none", n_out, o_result);
      end else begin
        mon_exp = exp_q.pop_front();
        if (o_result !== mon_exp) begin
          failures++;
          $display("FAIL result idx=%0d got=%0h exp=%0h", n_out, o_result, mon_exp);
        end else if (n_out <= 8) begin
          $display("xfer idx=%0d result=%0h", n_out, o_result);
        end
      end
    end
  end

  // Waits for IDLE, presents the Karatsuba triple of a*b for one accepted edge.
  task automatic send(input logic [255:0] a, input logic [255:0] b,
                      input logic [R_WIDTH-1:0] exp, input bit push);
    logic [128:0] sa, sb;
    int n;
    n = 0;
    while (!o_ready && n < 1000) begin
      @(posedge i_clk); #1;
      n++;
    end
    if (!o_ready) chk("send_ready_timeout", {259'd0, o_ready}, 260'd1);
    sa  = {1'b0, a[255:128]} + {1'b0, a[127:0]};
    sb  = {1'b0, b[255:128]} + {1'b0, b[127:0]};
    i_H = {132'd0, a[255:128]} * {132'd0, b[255:128]};
    i_M = {131'd0, sa} * {131'd0, sb};
    i_L = {132'd0, a[127:0]} * {132'd0, b[127:0]};
    if (push) begin
      exp_q.push_back(exp);
      n_in++;
    end
    i_valid = 1'b1;
    @(posedge i_clk); #1;
    i_valid = 1'b0;
  endtask

  task automatic wait_drain(input int budget);
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < budget) begin
      @(posedge i_clk); #1;
      n++;
    end
    chk("drain_pending", exp_q.size(), 260'd0);
  endtask

  initial begin
    logic [255:0] ra, rb;
    i_rst = 1'b1; i_valid = 1'b0; i_ready = 1'b1;
    i_H = '0; i_M = '0; i_L = '0;
    stall_en = 1'b0;
    repeat (2) @(posedge i_clk);
    #1;
    chk("reset_o_ready", o_ready, 260'd1);
    chk("reset_o_valid", o_valid, 260'd0);
    chk("reset_o_result", o_result, 260'd0);
    i_rst = 1'b0;

    // a=b=1: latency of exactly 4 edges after accept
    send(256'd1, 256'd1, 255'd1, 1'b1);
    chk("lat_busy_o_ready", o_ready, 260'd0);
    for (int i = 1; i <= 3; i++) begin
      @(posedge i_clk); #1;
      chk($sformatf("lat_early_valid_%0d", i), o_valid, 260'd0);
    end
    @(posedge i_clk); #1;
    chk("lat_valid_at_4", o_valid, 260'd1);
    @(posedge i_clk); #1;
    chk("lat_valid_cleared", o_valid, 260'd0);
    chk("lat_ready_back", o_ready, 260'd1);

    // 2^255 * 1 == 19; (2^256-1)^2 == 37^2 == 1369
    send(256'd1 << 255, 256'd1, 255'd19, 1'b1);
    send({256{1'b1}}, {256{1'b1}}, 255'd1369, 1'b1);
    wait_drain(100);

    // Backpressure with (p-1)*2 == p-2 held in OUT
    i_ready = 1'b0;
    send(P_MOD - 256'd1, 256'd2, P_MOD[254:0] - 255'd2, 1'b1);
    repeat (4) begin
      @(posedge i_clk); #1;
    end
    for (int i = 0; i < 10; i++) begin
      chk("bp_o_valid", o_valid, 260'd1);
      chk("bp_o_ready", o_ready, 260'd0);
      chk("bp_o_result", o_result, {5'd0, P_MOD[254:0] - 255'd2});
      if (i == 4) begin
        i_H = 260'd7; i_M = 260'd100; i_L = 260'd9;
        i_valid = 1'b1;
      end else begin
        i_valid = 1'b0;
      end
      @(posedge i_clk); #1;
    end
    i_valid = 1'b0;
    i_ready = 1'b1;
    @(posedge i_clk); #1;
    chk("bp_release_valid", o_valid, 260'd0);
    chk("bp_release_ready", o_ready, 260'd1);
    repeat (6) @(posedge i_clk);
    #1;
    chk("bp_no_extra_valid", o_valid, 260'd0);
    chk("bp_single_xfer", exp_q.size(), 260'd0);

    // Reset asserted while the FSM sits in FD1
    send(256'd3, 256'd7, 255'd0, 1'b0);
    @(posedge i_clk); #1;
    i_rst = 1'b1;
    @(posedge i_clk); #1;
    chk("abort_o_valid", o_valid, 260'd0);
    chk("abort_o_result", o_result, 260'd0);
    chk("abort_o_ready", o_ready, 260'd1);
    i_rst = 1'b0;
    send(256'd3, 256'd5, 255'd15, 1'b1);
    wait_drain(100);

    // Back-to-back random operands with random downstream stalls
    stall_en = 1'b1;
    fork
      begin
        while (stall_en) begin
          @(posedge i_clk); #1;
          i_ready = ($urandom_range(0, 3) != 0);
        end
        i_ready = 1'b1;
      end
      begin
        for (int t = 0; t < 2000; t++) begin
          ra = {$urandom(), $urandom(), $urandom(), $urandom(),
                $urandom(), $urandom(), $urandom(), $urandom()};
          rb = {$urandom(), $urandom(), $urandom(), $urandom(),
                $urandom(), $urandom(), $urandom(), $urandom()};
          send(ra, rb, golden(ra, rb), 1'b1);
        end
        wait_drain(5000);
        stall_en = 1'b0;
      end
    join
    repeat (3) @(posedge i_clk);
    #1;
    chk("xfer_count", n_out, n_in);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
